// File: rtl/oled_text_terminal.sv
// Character terminal front end for the PMOD OLED text path.
// Consumes a byte stream, keeps a cursor and a character buffer, handles
// scroll/clear sequences, and hands double-buffered snapshots to OLED_interface.
module oled_text_terminal #(
    parameter int unsigned NUM_ASCII_COL = 12,
    parameter int unsigned NUM_ASCII_ROW = 8,
    parameter bit          SCROLL_EN     = 1'b1,
    localparam int unsigned CW = $clog2(NUM_ASCII_COL),
    localparam int unsigned RW = $clog2(NUM_ASCII_ROW)
) (
    input  logic                                     i_CLK,
    input  logic                                     i_RST_N,
    input  logic                                     i_VALID,
    input  logic [7:0]                               i_DATA,
    output logic                                     o_READY,
    input  logic                                     i_DISP_READY,
    output logic                                     o_START,
    output logic [NUM_ASCII_COL*NUM_ASCII_ROW*8-1:0] o_ASCII,
    output logic [RW-1:0]                            o_CUR_ROW,
    output logic [CW-1:0]                            o_CUR_COL,
    output logic                                     o_DIRTY
);

    localparam int unsigned TOTAL    = NUM_ASCII_COL * NUM_ASCII_ROW;
    localparam int unsigned ROW_BITS = NUM_ASCII_COL * 8;
    localparam int unsigned BUF_BITS = TOTAL * 8;
    localparam int unsigned BW       = $clog2(BUF_BITS);
    localparam logic [CW-1:0] COL_LAST = CW'(NUM_ASCII_COL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ASCII_ROW - 1);

    typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} state_t;

    state_t                state;
    logic [BUF_BITS-1:0]   work_buf;
    logic [RW-1:0]         cur_row;
    logic [CW-1:0]         cur_col;
    logic [RW-1:0]         scan_row;
    logic                  dirty;
    logic                  busy;

    logic                  accept;
    logic                  printable;
    logic                  col_last;
    logic                  row_last;
    logic                  do_adv;
    logic                  start_cond;
    logic [BW-1:0]         cell_lo;
    logic [BW-1:0]         bs_lo;
    logic [BW-1:0]         scan_lo;
    logic [BW-1:0]         next_lo;

    assign o_READY   = (state == IDLE);
    assign o_CUR_ROW = cur_row;
    assign o_CUR_COL = cur_col;
    assign o_DIRTY   = dirty;

    // Decode the incoming byte and derive buffer bit offsets (cell k sits at (TOTAL-1-k)*8).
    always_comb begin
        accept     = i_VALID && (state == IDLE);
        printable  = (i_DATA >= 8'h20) && (i_DATA <= 8'h7E);
        col_last   = (cur_col == COL_LAST);
        row_last   = (cur_row == ROW_LAST);
        do_adv     = accept && ((printable && col_last) || (i_DATA == 8'h0A));
        start_cond = dirty && (state == IDLE) && i_DISP_READY && !busy;
        cell_lo    = BW'((TOTAL - 1 - (NUM_ASCII_COL * 32'(cur_row) + 32'(cur_col))) * 8);
        bs_lo      = cell_lo + BW'(8);
        scan_lo    = BW'((NUM_ASCII_ROW - 1 - 32'(scan_row)) * ROW_BITS);
        next_lo    = scan_lo - BW'(ROW_BITS);
    end

    // Terminal FSM: byte interpretation, scroll/clear sequencing and snapshot handoff.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state    <= IDLE;
            work_buf <= {TOTAL{8'h20}};
            o_ASCII  <= {TOTAL{8'h20}};
            cur_row  <= '0;
            cur_col  <= '0;
            scan_row <= '0;
            dirty    <= 1'b0;
            busy     <= 1'b0;
            o_START  <= 1'b0;
        end else begin
            o_START <= start_cond;
            if (start_cond) begin
                o_ASCII <= work_buf;
                dirty   <= 1'b0;
                busy    <= 1'b1;
            end else if (!i_DISP_READY) begin
                busy <= 1'b0;
            end

            // Later dirty <= 1 assignments override the snapshot clear above,
            // so a write on the snapshot edge keeps the buffer marked dirty.
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            work_buf[cell_lo +: 8] <= i_DATA;
                            dirty   <= 1'b1;
                            cur_col <= col_last ? '0 : cur_col + CW'(1);
                        end else begin
                            case (i_DATA)
                                8'h0A: cur_col <= '0;
                                8'h0D: cur_col <= '0;
                                8'h08: begin
                                    if (cur_col != '0) begin
                                        cur_col              <= cur_col - CW'(1);
                                        work_buf[bs_lo +: 8] <= 8'h20;
                                        dirty                <= 1'b1;
                                    end
                                end
                                8'h0C: begin
                                    state    <= CLEAR;
                                    scan_row <= '0;
                                    cur_row  <= '0;
                                    cur_col  <= '0;
                                    dirty    <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        if (do_adv) begin
                            if (!row_last) begin
                                cur_row <= cur_row + RW'(1);
                            end else if (SCROLL_EN) begin
                                state    <= SCROLL;
                                scan_row <= '0;
                                dirty    <= 1'b1;
                            end else begin
                                cur_row <= '0;
                            end
                        end
                    end
                end
                SCROLL: begin
                    dirty <= 1'b1;
                    if (scan_row == ROW_LAST) begin
                        work_buf[scan_lo +: ROW_BITS] <= {NUM_ASCII_COL{8'h20}};
                        state <= IDLE;
                    end else begin
                        work_buf[scan_lo +: ROW_BITS] <= work_buf[next_lo +: ROW_BITS];
                        scan_row <= scan_row + RW'(1);
                    end
                end
                CLEAR: begin
                    dirty <= 1'b1;
                    work_buf[scan_lo +: ROW_BITS] <= {NUM_ASCII_COL{8'h20}};
                    if (scan_row == ROW_LAST) begin
                        state <= IDLE;
                    end else begin
                        scan_row <= scan_row + RW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_text_terminal.sv
// Bench for oled_text_terminal: one scrolling and one wrapping instance,
// each compared against an array-based character-terminal model.
module tb_oled_text_terminal;

    localparam int COL = 12;
    localparam int ROW = 8;
    localparam int TOT = COL * ROW;
    localparam int FW  = TOT * 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    data = 8'h00;
    logic [1:0]    valid = 2'b00;
    logic [1:0]    disp = 2'b00;
    logic [1:0]    rdy;
    logic [1:0]    start;
    logic [1:0]    dirty;
    logic [FW-1:0] ascii0, ascii1;
    logic [2:0]    crow0, crow1;
    logic [3:0]    ccol0, ccol1;

    int tests = 0;
    int failed = 0;
    int nstart[2] = '{0, 0};

    // model state per instance: 0 = scrolling, 1 = wrapping
    logic [7:0]    mb [2][TOT];
    int            mr[2], mc[2];
    bit            md[2];
    logic [FW-1:0] snap[2];

    oled_text_terminal #(.NUM_ASCII_COL(COL), .NUM_ASCII_ROW(ROW), .SCROLL_EN(1'b1)) dut_s (
        .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(valid[0]), .i_DATA(data), .o_READY(rdy[0]),
        .i_DISP_READY(disp[0]), .o_START(start[0]), .o_ASCII(ascii0),
        .o_CUR_ROW(crow0), .o_CUR_COL(ccol0), .o_DIRTY(dirty[0]));

    oled_text_terminal #(.NUM_ASCII_COL(COL), .NUM_ASCII_ROW(ROW), .SCROLL_EN(1'b0)) dut_w (
        .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(valid[1]), .i_DATA(data), .o_READY(rdy[1]),
        .i_DISP_READY(disp[1]), .o_START(start[1]), .o_ASCII(ascii1),
        .o_CUR_ROW(crow1), .o_CUR_COL(ccol1), .o_DIRTY(dirty[1]));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start[0]) nstart[0] <= nstart[0] + 1;
        if (start[1]) nstart[1] <= nstart[1] + 1;
    end

    function automatic logic [FW-1:0] get_ascii(input int s);
        return (s == 0) ? ascii0 : ascii1;
    endfunction

    function automatic int get_row(input int s);
        return (s == 0) ? int'(crow0) : int'(crow1);
    endfunction

    function automatic int get_col(input int s);
        return (s == 0) ? int'(ccol0) : int'(ccol1);
    endfunction

    function automatic logic [FW-1:0] model_flat(input int s);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < TOT; k++) f[(TOT-1-k)*8 +: 8] = mb[s][k];
        return f;
    endfunction

    function automatic logic [FW-1:0] all_spaces();
        logic [FW-1:0] f;
        for (int k = 0; k < TOT; k++) f[k*8 +: 8] = 8'h20;
        return f;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < TOT; k++) mb[s][k] = 8'h20;
            mr[s] = 0; mc[s] = 0; md[s] = 1'b0;
            snap[s] = all_spaces();
        end
    endtask

    task automatic model_advance(input int s, output int busy);
        busy = 0;
        if (mr[s] < ROW - 1) begin
            mr[s]++;
        end else if (s == 0) begin
            for (int k = 0; k < TOT - COL; k++) mb[s][k] = mb[s][k+COL];
            for (int k = TOT - COL; k < TOT; k++) mb[s][k] = 8'h20;
            md[s] = 1'b1;
            busy = ROW;
        end else begin
            mr[s] = 0;
        end
    endtask

    task automatic model_step(input int s, input logic [7:0] b, output int busy);
        busy = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            mb[s][mr[s]*COL + mc[s]] = b;
            md[s] = 1'b1;
            if (mc[s] == COL - 1) begin
                mc[s] = 0;
                model_advance(s, busy);
            end else begin
                mc[s]++;
            end
        end else if (b == 8'h0A) begin
            mc[s] = 0;
            model_advance(s, busy);
        end else if (b == 8'h0D) begin
            mc[s] = 0;
        end else if (b == 8'h08) begin
            if (mc[s] > 0) begin
                mc[s]--;
                mb[s][mr[s]*COL + mc[s]] = 8'h20;
                md[s] = 1'b1;
            end
        end else if (b == 8'h0C) begin
            for (int k = 0; k < TOT; k++) mb[s][k] = 8'h20;
            mr[s] = 0; mc[s] = 0; md[s] = 1'b1;
            busy = ROW;
        end
    endtask

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte, wait for acceptance, then compare cursor, busy time, dirty and the snapshot.
    task automatic send(input int s, input logic [7:0] b);
        int n;
        int exp_busy;
        @(negedge clk);
        data = b;
        valid[s] = 1'b1;
        n = 0;
        while (!rdy[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", FW'(n < 50), FW'(1));
        @(negedge clk);
        valid[s] = 1'b0;
        model_step(s, b, exp_busy);
        check("cur_row", FW'(get_row(s)), FW'(mr[s]));
        check("cur_col", FW'(get_col(s)), FW'(mc[s]));
        n = 0;
        while (!rdy[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("busy_cycles", FW'(n), FW'(exp_busy));
        check("dirty", FW'(dirty[s]), FW'(md[s]));
        check("ascii_static", get_ascii(s), snap[s]);
    endtask

    // Raise display-ready, expect one start iff the model is dirty, compare the snapshot.
    task automatic flush(input int s, input bit keep_high);
        int n0;
        int exp_n;
        @(negedge clk);
        disp[s] = 1'b1;
        n0 = nstart[s];
        exp_n = md[s] ? 1 : 0;
        if (md[s]) snap[s] = model_flat(s);
        md[s] = 1'b0;
        repeat (5) @(negedge clk);
        check("start_count", FW'(nstart[s] - n0), FW'(exp_n));
        check("snapshot", get_ascii(s), snap[s]);
        check("dirty_after_start", FW'(dirty[s]), FW'(0));
        if (!keep_high) begin
            disp[s] = 1'b0;
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] rnd_byte();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 70) return 8'($urandom_range(32, 126));
        if (r < 80) return 8'h0A;
        if (r < 86) return 8'h0D;
        if (r < 94) return 8'h08;
        if (r < 96) return 8'h0C;
        if (r < 98) return 8'h1B;
        return 8'($urandom_range(127, 255));
    endfunction

    initial begin
        int n;
        int b;
        int n0;

        model_reset();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", FW'(rdy[s]), FW'(1));
            check("rst_start", FW'(start[s]), FW'(0));
            check("rst_dirty", FW'(dirty[s]), FW'(0));
            check("rst_row", FW'(get_row(s)), FW'(0));
            check("rst_col", FW'(get_col(s)), FW'(0));
            check("rst_ascii", get_ascii(s), all_spaces());
        end
        rst_n = 1'b1;

        // "HI" then refresh
        send(0, 8'h48);
        send(0, 8'h49);
        flush(0, 1'b0);
        check("hi_top", FW'(ascii0[FW-1 -: 16]), FW'(16'h4849));

        // fill rows 'A'..'H' (11 chars + LF each); last LF scrolls or wraps
        for (int s = 0; s < 2; s++) begin
            send(s, 8'h0C);
            for (int r = 0; r < ROW; r++) begin
                for (int c = 0; c < COL - 1; c++) send(s, 8'(8'h41 + r));
                send(s, 8'h0A);
            end
            flush(s, 1'b0);
        end

        // 12 printables wrap to next row, 13th lands at (1,0)
        send(0, 8'h0C);
        for (int c = 0; c < COL + 1; c++) send(0, 8'(8'h61 + c));
        flush(0, 1'b0);

        // backspace at column 0 is a no-op; "AB" BS blanks column 1
        send(0, 8'h0C);
        flush(0, 1'b0);
        send(0, 8'h08);
        send(0, 8'h41);
        send(0, 8'h42);
        send(0, 8'h08);
        flush(0, 1'b0);

        // form feed with valid held: next byte waits exactly ROW busy cycles
        for (int k = 0; k < TOT - 1; k++) send(0, 8'(8'h30 + (k % 10)));
        @(negedge clk);
        data = 8'h0C;
        valid[0] = 1'b1;
        @(negedge clk);
        data = 8'h5A;
        model_step(0, 8'h0C, b);
        n = 0;
        while (!rdy[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ff_held_busy", FW'(n), FW'(ROW));
        check("ff_cursor_row", FW'(crow0), FW'(0));
        check("ff_cursor_col", FW'(ccol0), FW'(0));
        @(negedge clk);
        valid[0] = 1'b0;
        model_step(0, 8'h5A, b);
        check("ff_next_col", FW'(ccol0), FW'(1));
        flush(0, 1'b0);

        // display ready held high: no second start until it toggles
        send(0, 8'h31);
        flush(0, 1'b1);
        n0 = nstart[0];
        send(0, 8'h32);
        send(0, 8'h33);
        repeat (4) @(negedge clk);
        check("no_restart_held", FW'(nstart[0] - n0), FW'(0));
        check("held_dirty", FW'(dirty[0]), FW'(1));
        disp[0] = 1'b0;
        @(negedge clk);
        flush(0, 1'b0);

        // randomized streams
        for (int i = 0; i < 400; i++) begin
            send(0, rnd_byte());
            if (i % 40 == 39) flush(0, 1'b0);
        end
        flush(0, 1'b0);
        for (int i = 0; i < 150; i++) begin
            send(1, rnd_byte());
            if (i % 30 == 29) flush(1, 1'b0);
        end
        flush(1, 1'b0);

        // reset in the middle of a scroll
        send(0, 8'h0C);
        for (int r = 0; r < ROW - 1; r++) send(0, 8'h0A);
        send(0, 8'h51);
        @(negedge clk);
        data = 8'h0A;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_scroll_busy", FW'(rdy[0]), FW'(0));
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_ready", FW'(rdy[0]), FW'(1));
        check("mid_rst_row", FW'(crow0), FW'(0));
        check("mid_rst_dirty", FW'(dirty[0]), FW'(0));
        check("mid_rst_ascii", ascii0, all_spaces());
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h52);
        flush(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/oled_text_terminal.md
# oled_text_terminal

Character-terminal front end for the PMOD OLED text path: accepts a byte stream over a valid/ready handshake, interprets printable ASCII and control codes, maintains a cursor and a NUM_ASCII_ROW x NUM_ASCII_COL character buffer with optional scroll. It presents a double-buffered flat character vector to OLED_interface's i_ASCII and generates its start pulse. This replaces hard-coded string literals on i_ASCII with live, streamed text.

## Interface
- NUM_ASCII_COL, 12, characters per row (96-pixel panel / 8)
- NUM_ASCII_ROW, 8, character rows (64-pixel panel / 8)
- SCROLL_EN, 1, 1: line feed past last row scrolls up; 0: cursor wraps to row 0
- CW = $clog2(NUM_ASCII_COL), RW = $clog2(NUM_ASCII_ROW) (derived, not overridable)

- i_CLK  in  1  single clock for all logic
- i_RST_N  in  1  asynchronous, active-low reset
- i_VALID  in  1  i_DATA valid
- i_DATA  in  8  character/control byte
- o_READY  out  1  byte accepted on i_VALID & o_READY at rising i_CLK
- i_DISP_READY  in  1  OLED_interface o_READY
- o_START  out  1  one-cycle refresh request to OLED_interface i_START
- o_ASCII  out  NUM_ASCII_COL*NUM_ASCII_ROW*8  snapshot to OLED_interface i_ASCII
- o_CUR_ROW  out  RW  cursor row
- o_CUR_COL  out  CW  cursor column
- o_DIRTY  out  1  buffer changed since last snapshot

## Operation
- Cell (r,c), k = r*NUM_ASCII_COL + c, occupies o_ASCII[(TOTAL-1-k)*8 +: 8], TOTAL = cols*rows: row 0 col 0 in the top byte, matching string-literal order.
- States: IDLE, SCROLL, CLEAR. o_READY = (state == IDLE).
- Accepted byte in IDLE:
  - 0x20-0x7E: write at cursor, set dirty; col+1; at col == NUM_ASCII_COL-1 -> col 0, line advance.
  - 0x0A LF: col 0, line advance. 0x0D CR: col 0.
  - 0x08 BS: col > 0 -> col-1, write 0x20 there, set dirty; col == 0 -> no-op.
  - 0x0C FF: enter CLEAR.
  - any other byte: consumed, ignored.
- Line advance: row < NUM_ASCII_ROW-1 -> row+1. At last row: SCROLL_EN=1 -> enter SCROLL, row stays last; SCROLL_EN=0 -> row 0, no buffer change.
- SCROLL: one row per cycle, row i <= row i+1 for i = 0..NUM_ASCII_ROW-2 (NUM_ASCII_ROW-1 cycles), then last row <= all 0x20 (1 cycle); total NUM_ASCII_ROW cycles, then IDLE; dirty set.
- CLEAR: row i <= all 0x20, one row per cycle, NUM_ASCII_ROW cycles; cursor <= (0,0); dirty set; then IDLE.
- Refresh: busy flag set with o_START, cleared on first cycle i_DISP_READY is sampled 0. o_START = 1 for one cycle when dirty & state == IDLE & i_DISP_READY & !busy. Same edge: o_ASCII <= working buffer, dirty <= 0. A write on that same edge lands in the buffer after the copy and sets dirty again (write wins over clear).
- o_ASCII changes only on an o_START edge; never mid-scroll or mid-clear.

## Timing
- Reset (async assert, sync release): buffer and o_ASCII all 0x20, cursor (0,0), state IDLE, o_READY 1, o_START 0, o_DIRTY 0, busy 0.
- Printable/CR/LF/BS: one byte per cycle, cursor outputs updated the cycle after acceptance.
- LF at last row with SCROLL_EN: o_READY low for exactly NUM_ASCII_ROW cycles starting next cycle.
- FF: o_READY low exactly NUM_ASCII_ROW cycles.
- o_START earliest one cycle after the dirtying edge; at most one o_START per i_DISP_READY low-to-high cycle.
- Reset mid-SCROLL/CLEAR: immediate return to reset state, partial work discarded.

## Test plan
- Reset then stream "HI": cell(0,0)=0x48, (0,1)=0x49, cursor (0,2); with i_DISP_READY=1 one o_START, o_ASCII top two bytes 0x4849, rest 0x20.
- 12 printables on row 0: cursor (1,0); 13th char lands at (1,0).
- SCROLL_EN=1, fill rows with 'A'..'H', LF at row 7: o_READY low 8 cycles, row 0='B'...row 6='H', row 7 spaces, cursor (7,0); SCROLL_EN=0 same input: buffer unchanged, cursor (0,0).
- BS at col 0 -> no change, no dirty; "AB",BS -> cell(0,1)=0x20, cursor (0,1).
- FF after filling screen: 8 busy cycles, all 0x20, cursor (0,0); i_VALID held across, byte after FF accepted only when o_READY returns.
- i_DISP_READY held 0 while writing: no o_START, o_ASCII static; raise -> single o_START, snapshot equals buffer; keep high with no low pulse -> no second o_START despite new writes until i_DISP_READY toggles low then high.
